// File: rtl/aes_block_serializer_if.sv
// Handshake bundle for the AES block serializer.
// Carries the 128-bit block input side and the byte-serial output side.
interface aes_block_serializer_if;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned BYTE_W  = 8;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] in_block;
    logic               out_valid;
    logic               out_ready;
    logic [BYTE_W-1:0]  out_byte;
    logic               out_first;
    logic               out_last;

    // Producer/consumer environment side
    modport master (
        output in_valid,
        output in_block,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_byte,
        input  out_first,
        input  out_last
    );

    // Serializer side
    modport slave (
        input  in_valid,
        input  in_block,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_byte,
        output out_first,
        output out_last
    );
endinterface

// File: rtl/aes_block_serializer.sv
// Streams 128-bit AES blocks out as 16 bytes, MSB first, through a two-slot
// ping-pong buffer so the next block loads while the current one drains.
module aes_block_serializer #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_block_serializer_if.slave bus,
    output logic [COUNT_W-1:0]    blocks_sent
);
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned IDX_W   = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(15);

    // State encodes slot occupancy directly
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0]   slot_q [2];

    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [BYTE_W-1:0]    out_byte_q, out_byte_d;
    logic                 out_first_q, out_first_d;
    logic                 out_last_q, out_last_d;

    logic                 accept_c;
    logic                 xfer_c;
    logic                 final_c;
    logic [BLOCK_W-1:0]   sel_block_c;
    logic [BLOCK_W-1:0]   shifted_c;

    assign accept_c = bus.in_valid && (state_q != ST_FULL);
    assign xfer_c   = (state_q != ST_EMPTY) && bus.out_ready;
    assign final_c  = xfer_c && (idx_q == LAST_IDX);

    // Next-state, pointer, counter and next-cycle output values
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        sel_block_c = slot_q[rd_ptr_q];
        shifted_c   = '0;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_byte_d  = '0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;

        case (state_q)
            ST_EMPTY: begin
                if (accept_c) state_d = ST_ONE;
            end
            ST_ONE: begin
                if (accept_c && !final_c)      state_d = ST_FULL;
                else if (!accept_c && final_c) state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (final_c) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept_c) wr_ptr_d = ~wr_ptr_q;

        if (xfer_c) begin
            if (final_c) begin
                idx_d    = '0;
                rd_ptr_d = ~rd_ptr_q;
                cnt_d    = cnt_q + COUNT_W'(1);
            end else begin
                idx_d    = idx_q + IDX_W'(1);
            end
        end

        // Forward the incoming block when it lands in the slot read next cycle
        if (accept_c && (wr_ptr_q == rd_ptr_d)) sel_block_c = bus.in_block;
        else                                     sel_block_c = slot_q[rd_ptr_d];
        shifted_c = sel_block_c << {idx_d, 3'b000};

        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
        if (out_valid_d) begin
            out_byte_d  = shifted_c[BLOCK_W-1 -: BYTE_W];
            out_first_d = (idx_d == '0);
            out_last_d  = (idx_d == LAST_IDX);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_byte_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
        end
    end

    // Slot storage is not cleared by reset
    always_ff @(posedge clk) begin
        if (!rst && accept_c) slot_q[wr_ptr_q] <= bus.in_block;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_byte  = out_byte_q;
    assign bus.out_first = out_first_q;
    assign bus.out_last  = out_last_q;
    assign blocks_sent   = cnt_q;
endmodule

// File: tb/tb_aes_block_serializer.sv
// Directed self-checking bench for aes_block_serializer.
module tb_aes_block_serializer;
    localparam int unsigned COUNT_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [COUNT_W-1:0] blocks_sent;
    int                 checks = 0;
    int                 errors = 0;

    aes_block_serializer_if bus ();

    aes_block_serializer #(.COUNT_W(COUNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .blocks_sent (blocks_sent)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] BLK_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] BLK_P = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] BLK_Q = 128'h00112233445566778899aabbccddeeff;

    logic [7:0] k_bytes [16] = '{8'h2b, 8'h7e, 8'h15, 8'h16, 8'h28, 8'hae, 8'hd2, 8'ha6,
                                 8'hab, 8'hf7, 8'h15, 8'h88, 8'h09, 8'hcf, 8'h4f, 8'h3c};
    logic [7:0] p_bytes [16] = '{8'h32, 8'h43, 8'hf6, 8'ha8, 8'h88, 8'h5a, 8'h30, 8'h8d,
                                 8'h31, 8'h31, 8'h98, 8'ha2, 8'he0, 8'h37, 8'h07, 8'h34};
    logic [7:0] q_bytes [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                                 8'h88, 8'h99, 8'haa, 8'hbb, 8'hcc, 8'hdd, 8'hee, 8'hff};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Move past the next rising edge; outputs are sampled 1ns later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_byte(input string tag, input logic [7:0] exp, input int idx);
        check({tag, ".valid"}, 128'(bus.out_valid), 128'(1'b1));
        check({tag, ".byte"},  128'(bus.out_byte),  128'(exp));
        check({tag, ".first"}, 128'(bus.out_first), 128'(idx == 0));
        check({tag, ".last"},  128'(bus.out_last),  128'(idx == 15));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.out_ready = 1'b0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check("rst.in_ready",  128'(bus.in_ready),  128'(1'b1));
        check("rst.out_valid", 128'(bus.out_valid), 128'(1'b0));
        check("rst.out_byte",  128'(bus.out_byte),  128'(8'h00));
        check("rst.out_first", 128'(bus.out_first), 128'(1'b0));
        check("rst.out_last",  128'(bus.out_last),  128'(1'b0));
        check("rst.count",     128'(blocks_sent),   128'(0));

        // Single block, out_ready high
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_block  = BLK_K;
        step();
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_byte("single", k_bytes[i], i);
            if (i == 15) check("single.count_pre", 128'(blocks_sent), 128'(0));
            step();
        end
        check("single.drained", 128'(bus.out_valid), 128'(1'b0));
        check("single.count",   128'(blocks_sent),   128'(1));

        // Backpressure at byte index 5
        bus.in_valid = 1'b1;
        bus.in_block = BLK_K;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_byte("bp.pre", k_bytes[i], i);
            step();
        end
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk_byte("bp.hold", 8'hae, 5);
        end
        bus.out_ready = 1'b1;
        for (int i = 5; i < 16; i++) begin
            chk_byte("bp.post", k_bytes[i], i);
            step();
        end
        check("bp.count", 128'(blocks_sent), 128'(2));

        // Back-to-back blocks with continuous in_valid
        bus.in_valid = 1'b1;
        bus.in_block = BLK_K;
        step();
        bus.in_block = BLK_P;
        for (int i = 0; i < 32; i++) begin
            chk_byte("b2b", (i < 16) ? k_bytes[i] : p_bytes[i-16], i % 16);
            check("b2b.in_ready", 128'(bus.in_ready), 128'((i == 0) || (i >= 16)));
            step();
            if (i == 0) bus.in_valid = 1'b0;
        end
        check("b2b.drained", 128'(bus.out_valid), 128'(1'b0));
        check("b2b.count",   128'(blocks_sent),   128'(4));

        // Full buffer: third block must wait for block 1 to drain
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_block  = BLK_K;
        step();
        bus.in_block  = BLK_P;
        step();
        bus.in_block  = BLK_Q;
        for (int s = 0; s < 3; s++) begin
            check("full.in_ready", 128'(bus.in_ready), 128'(1'b0));
            chk_byte("full.hold", 8'h2b, 0);
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_byte("full.k", k_bytes[i], i);
            check("full.k_ready", 128'(bus.in_ready), 128'(1'b0));
            step();
        end
        for (int j = 0; j < 32; j++) begin
            chk_byte("full.pq", (j < 16) ? p_bytes[j] : q_bytes[j-16], j % 16);
            if (j == 0) check("full.reopen", 128'(bus.in_ready), 128'(1'b1));
            step();
            if (j == 0) bus.in_valid = 1'b0;
        end
        check("full.drained", 128'(bus.out_valid), 128'(1'b0));
        check("full.count",   128'(blocks_sent),   128'(7));

        // Accept coincident with the byte-15 transfer
        bus.in_valid = 1'b1;
        bus.in_block = BLK_K;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            chk_byte("sim.k", k_bytes[i], i);
            step();
        end
        chk_byte("sim.k15", 8'h3c, 15);
        check("sim.ready15", 128'(bus.in_ready), 128'(1'b1));
        bus.in_valid = 1'b1;
        bus.in_block = BLK_P;
        step();
        bus.in_valid = 1'b0;
        check("sim.ready_after", 128'(bus.in_ready), 128'(1'b1));
        for (int i = 0; i < 16; i++) begin
            chk_byte("sim.p", p_bytes[i], i);
            step();
        end
        check("sim.drained", 128'(bus.out_valid), 128'(1'b0));
        check("sim.count",   128'(blocks_sent),   128'(9));

        // Reset mid-stream with a second block queued
        bus.in_valid = 1'b1;
        bus.in_block = BLK_K;
        step();
        bus.in_block = BLK_P;
        step();
        bus.in_valid = 1'b0;
        for (int i = 1; i < 7; i++) begin
            chk_byte("mid.k", k_bytes[i], i);
            step();
        end
        chk_byte("mid.k7", 8'ha6, 7);
        check("mid.full", 128'(bus.in_ready), 128'(1'b0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid.out_valid", 128'(bus.out_valid), 128'(1'b0));
        check("mid.in_ready",  128'(bus.in_ready),  128'(1'b1));
        check("mid.out_byte",  128'(bus.out_byte),  128'(8'h00));
        check("mid.count",     128'(blocks_sent),   128'(0));
        step();
        check("mid.idle", 128'(bus.out_valid), 128'(1'b0));
        bus.in_valid = 1'b1;
        bus.in_block = BLK_Q;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk_byte("mid.q", q_bytes[i], i);
            step();
        end
        check("mid.drained", 128'(bus.out_valid), 128'(1'b0));
        check("mid.count_q", 128'(blocks_sent),   128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
